walk_request_bank: RTL and testbench
====================================

Name: walk_request_bank

Overview:
- Multi-channel successor to the single-bit walk latch for the traffic light controller.
- Per crossing channel: synchronises and debounces the raw pedestrian button, then latches a pending walk request.
- Ages each pending request on a slow tick and presents one request at a time to the phase FSM over a valid/ready handshake.
- Selects the next request round-robin, with urgent (aged) requests taking priority.

Parameters:
- N_CH, 4, number of pedestrian crossing channels (1..16)
- SYNC_STAGES, 2, flip-flop stages in each button synchroniser (>=2)
- DEBOUNCE_CYCLES, 4, consecutive high synchronised samples needed to accept a press (>=1)
- AGE_W, 4, width of each per-channel age counter
- AGE_LIMIT, 10, age (in ticks) at or above which a pending request is urgent (< 2^AGE_W)
- CH_W, $clog2(N_CH) (min 1), width of the channel index

Ports:
- clk  in  1  system clock
- WR_Reset  in  1  reset
- tick  in  1  one-cycle age strobe (e.g. 1 Hz), synchronous to clk
- btn  in  N_CH  raw asynchronous push buttons, active-high
- ch_enable  in  N_CH  per-channel enable; 0 masks the channel
- req_ready  in  1  phase FSM accepts the presented request
- req_valid  out  1  a request is presented
- req_ch  out  CH_W  index of the presented channel
- req_urgent  out  1  presented request has age >= AGE_LIMIT
- pending  out  N_CH  per-channel latched request flags
- age_max  out  AGE_W  largest age among pending channels (0 if none)

Behaviour:
- Reset: WR_Reset is asynchronous and active-high. It clears all synchronisers, debounce counters, pending, ages, the round-robin pointer, req_valid, req_ch, req_urgent and age_max to 0. Release is synchronised internally.
- Synchroniser: btn[i] passes through SYNC_STAGES flops giving s[i].
- Debounce counter per channel:
  - s[i]=0: counter clears to 0.
  - s[i]=1: counter increments, saturating at DEBOUNCE_CYCLES.
  - A press event fires in the single cycle the counter reaches DEBOUNCE_CYCLES. Holding the button gives exactly one event; a new event needs s[i] to return low first.
  - Latency from a stable btn rise to pending[i]=1 is SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles.
- Pending latch per channel:
  - Set on a press event when ch_enable[i]=1.
  - A press while already pending is ignored; age is not reset.
  - Cleared on handshake accept of channel i.
  - Cleared when ch_enable[i]=0; age also clears.
  - A press event in the same cycle as the clear: the clear wins and the press is dropped.
- Age per channel:
  - 0 when not pending.
  - While pending, increments on each tick, saturating at 2^AGE_W-1.
  - A tick in the same cycle as setting pending leaves age 0.
- Arbitration (registered, evaluated only when the output is idle or accepted):
  - If any pending channel has age >= AGE_LIMIT, grant the first such channel searching upward from rr_ptr with wrap-around.
  - Otherwise grant the first pending channel from rr_ptr with wrap.
  - Result is loaded into req_ch, req_urgent and req_valid=1 on the next clk. None pending gives req_valid=0.
- Handshake:
  - Accept = req_valid & req_ready.
  - While req_valid=1 and req_ready=0, req_valid, req_ch and req_urgent hold stable. No re-arbitration happens even if a more urgent channel appears.
  - On accept: pending[req_ch] and its age clear and rr_ptr <= req_ch+1 (mod N_CH). In the same cycle the arbiter selects from the remaining pending set, so back-to-back requests are possible.
  - If the presented channel is disabled while presented: req_valid drops next cycle with no accept, and rr_ptr is unchanged.
- age_max: registered maximum over the ages of pending channels, updated every cycle.
- Reset mid-operation: all state is lost and no request survives.

Decomposition:
- Shared package traffic_pkg: default widths, AGE_LIMIT default, tick-rate constant, clog2 helper.
- One sub-module: walk_btn_conditioner (synchroniser + debounce + press event, per channel, generated N_CH times).
- Pending, age, arbiter and handshake logic live in the top.

Test Plan:
1. Reset and single press: WR_Reset pulse, btn[2] high for 10 cycles with defaults -> pending=4'b0100 at cycle 7 after the rise, then req_valid=1 and req_ch=2. With req_ready=1, pending=0 and req_valid=0 the cycle after accept.
2. Bounce: btn[0] toggles 1,0,1,1,0 per cycle -> no press event and pending[0] stays 0. A steady 4+ cycle high after that gives exactly one set.
3. Round-robin: channels 0,1,3 pending, req_ready=1 continuously -> grant order 0,1,3. Re-press 0 and 1 -> order continues from rr_ptr=0, giving 0 then 1.
4. Urgency: channel 1 pending 12 ticks, channel 3 pending 2 ticks, rr_ptr=2 -> req_ch=1 with req_urgent=1 and age_max=12. Ages saturate at 15 after 20 ticks.
5. Backpressure and collision: req_ready=0 for 5 cycles -> req_ch and req_urgent stable throughout. A press on the presented channel in the accept cycle is dropped, so pending stays 0.
6. Disable and async reset: clear ch_enable[2] while req_ch=2 is presented -> req_valid=0 next cycle and no accept. Assert WR_Reset mid-clock -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared traffic-light controller constants and helpers.
package traffic_pkg;

  // Default geometry of the pedestrian request bank.
  localparam int unsigned N_CH_DEF            = 4;
  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned AGE_W_DEF           = 4;
  localparam int unsigned AGE_LIMIT_DEF       = 10;

  // Age strobe rate relative to the system clock.
  localparam int unsigned CLK_HZ   = 50_000_000;
  localparam int unsigned TICK_HZ  = 1;
  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;

  // Ceil(log2(v)), never less than 1 so single-entry indices keep one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(v)) r = 32'(i + 1);
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/walk_btn_conditioner.sv
// One pedestrian button: synchroniser, debounce counter and single press pulse.
module walk_btn_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic WR_Reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = clog2_min1(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Bring the raw button into the clk domain.
  always_ff @(posedge clk or posedge WR_Reset) begin
    if (WR_Reset) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
  end

  // Count consecutive high samples; pulse once when the count reaches the limit.
  always_ff @(posedge clk or posedge WR_Reset) begin
    if (WR_Reset) begin
      cnt_q <= '0;
      press <= 1'b0;
    end else begin
      if (!s)                   cnt_q <= '0;
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
      press <= s && (cnt_q == CNT_PRE);
    end
  end

endmodule

// File: rtl/walk_request_bank.sv
// Multi-channel pedestrian walk request bank with ageing and round-robin arbitration.
module walk_request_bank
  import traffic_pkg::*;
#(
  parameter int unsigned N_CH            = N_CH_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned AGE_W           = AGE_W_DEF,
  parameter int unsigned AGE_LIMIT       = AGE_LIMIT_DEF,
  parameter int unsigned CH_W            = clog2_min1(N_CH)
) (
  input  logic              clk,
  input  logic              WR_Reset,
  input  logic              tick,
  input  logic [N_CH-1:0]   btn,
  input  logic [N_CH-1:0]   ch_enable,
  input  logic              req_ready,
  output logic              req_valid,
  output logic [CH_W-1:0]   req_ch,
  output logic              req_urgent,
  output logic [N_CH-1:0]   pending,
  output logic [AGE_W-1:0]  age_max
);

  localparam int unsigned SUM_W = CH_W + 1;
  localparam logic [AGE_W-1:0] AGE_SAT = '1;
  localparam logic [AGE_W-1:0] AGE_URG = AGE_W'(AGE_LIMIT);

  logic [1:0]       rst_pipe;
  logic             rst_i;
  logic [N_CH-1:0]  press;
  logic [AGE_W-1:0] age_q [N_CH];
  logic [CH_W-1:0]  rr_ptr;

  logic             drop_c;
  logic             accept_c;
  logic [N_CH-1:0]  clr_c;
  logic [N_CH-1:0]  avail_c;
  logic [N_CH-1:0]  urg_vec_c;
  logic [CH_W-1:0]  ptr_c;
  logic [CH_W-1:0]  pick_u_c;
  logic [CH_W-1:0]  pick_n_c;
  logic [AGE_W-1:0] max_c;

  // First set bit of vec at or above ptr, wrapping past the top channel.
  function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] vec,
                                               input logic [CH_W-1:0] ptr);
    logic [N_CH-1:0]  rot;
    logic [SUM_W-1:0] sum;
    logic             hit;
    rot = N_CH'({vec, vec} >> ptr);
    hit = 1'b0;
    sum = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!hit && rot[k]) begin
        hit = 1'b1;
        sum = {1'b0, ptr} + SUM_W'(k);
      end
    end
    if (sum >= SUM_W'(N_CH)) sum = sum - SUM_W'(N_CH);
    return CH_W'(sum);
  endfunction

  // Asynchronous assert, synchronised release of the internal reset.
  always_ff @(posedge clk or posedge WR_Reset) begin
    if (WR_Reset) rst_pipe <= 2'b11;
    else          rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign rst_i = rst_pipe[1];

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_cond
      walk_btn_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_cond (
        .clk      (clk),
        .WR_Reset (rst_i),
        .btn      (btn[g]),
        .press    (press[g])
      );
    end
  endgenerate

  // Handshake decode, remaining-request set and next grant candidates.
  always_comb begin
    drop_c    = 1'b0;
    accept_c  = 1'b0;
    clr_c     = '0;
    avail_c   = '0;
    urg_vec_c = '0;
    ptr_c     = rr_ptr;
    drop_c    = req_valid && !ch_enable[req_ch];
    accept_c  = req_valid && req_ready && !drop_c;
    for (int i = 0; i < N_CH; i++) begin
      clr_c[i]     = accept_c && (req_ch == CH_W'(i));
      avail_c[i]   = pending[i] && ch_enable[i] && !clr_c[i];
      urg_vec_c[i] = avail_c[i] && (age_q[i] >= AGE_URG);
    end
    if (accept_c) begin
      if ({1'b0, req_ch} + SUM_W'(1) >= SUM_W'(N_CH)) ptr_c = '0;
      else                                             ptr_c = req_ch + CH_W'(1);
    end
    pick_u_c = rr_pick(urg_vec_c, ptr_c);
    pick_n_c = rr_pick(avail_c, ptr_c);
  end

  // Largest age among pending channels.
  always_comb begin
    max_c = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (pending[i] && (age_q[i] > max_c)) max_c = age_q[i];
    end
  end

  // Per-channel pending latch and saturating age counter.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      pending <= '0;
      for (int i = 0; i < N_CH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!ch_enable[i] || clr_c[i]) begin
          pending[i] <= 1'b0;
          age_q[i]   <= '0;
        end else if (!pending[i]) begin
          pending[i] <= press[i];
          age_q[i]   <= '0;
        end else if (tick && (age_q[i] != AGE_SAT)) begin
          age_q[i] <= age_q[i] + AGE_W'(1);
        end
      end
    end
  end

  // Presented request: hold under backpressure, re-arbitrate when idle or accepted.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      req_valid  <= 1'b0;
      req_ch     <= '0;
      req_urgent <= 1'b0;
      rr_ptr     <= '0;
    end else if (drop_c) begin
      req_valid  <= 1'b0;
      req_urgent <= 1'b0;
    end else if (!req_valid || accept_c) begin
      if (accept_c) rr_ptr <= ptr_c;
      if (|avail_c) begin
        req_valid  <= 1'b1;
        req_urgent <= |urg_vec_c;
        req_ch     <= (|urg_vec_c) ? pick_u_c : pick_n_c;
      end else begin
        req_valid  <= 1'b0;
        req_urgent <= 1'b0;
      end
    end
  end

  // Registered age summary.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) age_max <= '0;
    else       age_max <= max_c;
  end

endmodule

// File: tb/tb_walk_request_bank.sv
// Directed scoreboard bench for walk_request_bank with default parameters.
module tb_walk_request_bank;

  logic       clk;
  logic       WR_Reset;
  logic       tick;
  logic [3:0] btn;
  logic [3:0] ch_enable;
  logic       req_ready;
  logic       req_valid;
  logic [1:0] req_ch;
  logic       req_urgent;
  logic [3:0] pending;
  logic [3:0] age_max;

  typedef struct packed {
    logic [1:0] ch;
    logic       urg;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  walk_request_bank dut (
    .clk        (clk),
    .WR_Reset   (WR_Reset),
    .tick       (tick),
    .btn        (btn),
    .ch_enable  (ch_enable),
    .req_ready  (req_ready),
    .req_valid  (req_valid),
    .req_ch     (req_ch),
    .req_urgent (req_urgent),
    .pending    (pending),
    .age_max    (age_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] ch, input logic urg);
    exp_t e;
    e.ch  = ch;
    e.urg = urg;
    exp_q.push_back(e);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  // Hold a button mask long enough to register, then release and let it settle.
  task automatic press_mask(input logic [3:0] m);
    btn = m;
    repeat (7) step();
    btn = 4'b0000;
    repeat (3) step();
  endtask

  // Wait for a presented request, compare it with the scoreboard and accept it.
  task automatic accept_one(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (!req_valid && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, req_valid, 1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_ch"}, req_ch, e.ch);
      chk({tag, "_urg"}, req_urgent, e.urg);
    end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    WR_Reset  = 1'b1;
    tick      = 1'b0;
    btn       = 4'b0000;
    ch_enable = 4'b1111;
    req_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_valid", req_valid, 0);
    chk("rst_pending", pending, 0);
    chk("rst_age_max", age_max, 0);
    repeat (3) step();
    WR_Reset = 1'b0;
    repeat (4) step();
    chk("idle_valid", req_valid, 0);
    chk("idle_ch", req_ch, 0);
    chk("idle_urg", req_urgent, 0);

    // Single press latency and accept
    btn = 4'b0100;
    repeat (6) step();
    chk("t1_pend_early", pending, 4'b0000);
    step();
    chk("t1_pend_set", pending, 4'b0100);
    chk("t1_valid_early", req_valid, 0);
    step();
    chk("t1_valid", req_valid, 1);
    push_exp(2'd2, 1'b0);
    accept_one("t1_acc");
    chk("t1_pend_clr", pending, 4'b0000);
    chk("t1_valid_clr", req_valid, 0);
    step();
    btn = 4'b0000;
    repeat (3) step();
    chk("t1_hold_once", pending, 4'b0000);

    // Bounce rejection, then a clean press
    btn = 4'b0001; step();
    btn = 4'b0000; step();
    btn = 4'b0001; step();
    btn = 4'b0001; step();
    btn = 4'b0000; step();
    repeat (8) step();
    chk("t2_bounce_pend", pending, 4'b0000);
    chk("t2_bounce_valid", req_valid, 0);
    btn = 4'b0001;
    repeat (7) step();
    chk("t2_clean_pend", pending, 4'b0001);
    push_exp(2'd0, 1'b0);
    accept_one("t2_acc");
    repeat (6) step();
    chk("t2_one_event", pending, 4'b0000);
    btn = 4'b0000;
    repeat (3) step();

    // Round-robin order from a fresh pointer
    WR_Reset = 1'b1;
    step();
    WR_Reset = 1'b0;
    repeat (4) step();
    push_exp(2'd0, 1'b0);
    push_exp(2'd1, 1'b0);
    push_exp(2'd3, 1'b0);
    btn = 4'b1011;
    repeat (7) step();
    chk("t3_pend", pending, 4'b1011);
    btn = 4'b0000;
    accept_one("t3_a");
    accept_one("t3_b");
    accept_one("t3_c");
    repeat (3) step();
    push_exp(2'd0, 1'b0);
    push_exp(2'd1, 1'b0);
    press_mask(4'b0011);
    accept_one("t3_d");
    accept_one("t3_e");
    chk("t3_drained", pending, 4'b0000);

    // Urgency: channel 0 is held, channels 1 and 3 age behind it
    press_mask(4'b0001);
    chk("t4_hold_valid", req_valid, 1);
    chk("t4_hold_ch", req_ch, 2'd0);
    press_mask(4'b0010);
    do_ticks(10);
    press_mask(4'b1000);
    do_ticks(2);
    step();
    chk("t4_pend", pending, 4'b1011);
    chk("t4_age_max_a", age_max, 12);
    ch_enable = 4'b1110;
    step();
    chk("t4_drop_valid", req_valid, 0);
    ch_enable = 4'b1111;
    step();
    chk("t4_urg_valid", req_valid, 1);
    chk("t4_urg_ch", req_ch, 2'd1);
    chk("t4_urg_flag", req_urgent, 1);
    chk("t4_age_max_b", age_max, 12);

    // Backpressure holds the presented request stable
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_bp_valid", req_valid, 1);
      chk("t5_bp_ch", req_ch, 2'd1);
      chk("t5_bp_urg", req_urgent, 1);
    end
    do_ticks(20);
    chk("t4_age_sat", age_max, 15);
    push_exp(2'd1, 1'b1);
    accept_one("t4_acc");

    // Press on the presented channel collides with its accept
    chk("t5_next_valid", req_valid, 1);
    btn = 4'b1000;
    repeat (6) step();
    push_exp(2'd3, 1'b1);
    accept_one("t5_coll");
    chk("t5_coll_pend", pending, 4'b0000);
    repeat (4) step();
    chk("t5_coll_pend_late", pending, 4'b0000);
    chk("t5_coll_valid", req_valid, 0);
    btn = 4'b0000;
    repeat (3) step();

    // Disable while presented leaves the pointer alone
    press_mask(4'b0100);
    chk("t6_pres_ch", req_ch, 2'd2);
    ch_enable = 4'b1011;
    step();
    chk("t6_dis_valid", req_valid, 0);
    chk("t6_dis_pend", pending, 4'b0000);
    ch_enable = 4'b1111;
    step();
    push_exp(2'd0, 1'b0);
    push_exp(2'd3, 1'b0);
    press_mask(4'b1001);
    accept_one("t6_a");
    accept_one("t6_b");

    // Asynchronous reset in the middle of a clock period
    press_mask(4'b0010);
    chk("t6_pre_valid", req_valid, 1);
    chk("t6_pre_ch", req_ch, 2'd1);
    #2;
    WR_Reset = 1'b1;
    #1;
    chk("t6_async_valid", req_valid, 0);
    chk("t6_async_ch", req_ch, 0);
    chk("t6_async_pend", pending, 0);
    chk("t6_async_age", age_max, 0);
    step();
    WR_Reset = 1'b0;
    repeat (5) step();
    chk("t6_post_valid", req_valid, 0);
    chk("t6_post_pend", pending, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
